// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART/ALU frame sequencer: FSM state encoding
// and the opcode values the ALU decodes.
package alu_uart_pkg;

    // State encoding, 3 bits wide
    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_CALC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        CALC    = ST_CALC,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX
    } state_t;

    // Opcodes shared with the ALU (6-bit function field)
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_RESET = 6'b000000;

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte timeout for the frame sequencer. Saturating up counter:
// 'clear' has priority, 'enable' advances it, 'expired' is high once the
// count has reached LIMIT-1 and stays there until cleared.
module bridge_timeout #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(LIMIT - 1));

    // Count idle cycles; hold at the expiry value instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_bridge.sv
// Frame sequencer between the UART and the combinational ALU. Gathers
// operand A, operand B and the opcode byte, holds them on the ALU inputs,
// captures the result and requests one transmission of it.
//
// Strobe semantics: i_rx_done and i_tx_done are single-cycle strobes with no
// back-pressure. A byte strobe is consumed only in WAIT_A/WAIT_B/WAIT_OP and
// silently dropped elsewhere; i_tx_done is consumed only in WAIT_TX.
// o_tx_start is a single-cycle request and i_rx_data is sampled on the same
// edge that samples i_rx_done.
module alu_uart_bridge
    import alu_uart_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int OP_CODE_SIZE   = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [DATA_BITS-1:0]    i_rx_data,
    input  logic                    i_rx_done,
    input  logic [DATA_BITS-1:0]    i_alu_result,
    input  logic                    i_tx_done,
    output logic [DATA_BITS-1:0]    o_dato_a,
    output logic [DATA_BITS-1:0]    o_dato_b,
    output logic [OP_CODE_SIZE-1:0] o_op_code,
    output logic [DATA_BITS-1:0]    o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t state;
    logic   in_wait_operand;
    logic   tmo_clear;
    logic   tmo_expired;

    // The timeout only runs while a frame is partially received; every
    // accepted byte restarts it.
    assign in_wait_operand = (state == WAIT_B) || (state == WAIT_OP);
    assign tmo_clear       = !in_wait_operand || i_rx_done;

    bridge_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk     (i_clk),
        .rst     (i_reset),
        .clear   (tmo_clear),
        .enable  (in_wait_operand),
        .expired (tmo_expired)
    );

    // Frame FSM with all data registers and registered status outputs;
    // a byte arriving in the expiry cycle beats the timeout
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= WAIT_A;
            o_dato_a   <= '0;
            o_dato_b   <= '0;
            o_op_code  <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_dato_a <= i_rx_data;
                        state    <= WAIT_B;
                        o_busy   <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_dato_b <= i_rx_data;
                        state    <= WAIT_OP;
                    end else if (tmo_expired) begin
                        state  <= WAIT_A;
                        o_busy <= 1'b0;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op_code <= i_rx_data[OP_CODE_SIZE-1:0];
                        state     <= CALC;
                    end else if (tmo_expired) begin
                        state  <= WAIT_A;
                        o_busy <= 1'b0;
                    end
                end
                CALC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state  <= WAIT_A;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= WAIT_A;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_bridge.sv
// Bench for alu_uart_bridge: bench-side ALU, frame-level reference model,
// per-cycle compare process and directed frames with literal results.
module tb_alu_uart_bridge;
    import alu_uart_pkg::*;

    localparam int DW  = 8;
    localparam int OW  = 6;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic          tx_done = 1'b0;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] dato_a, dato_b, tx_data;
    logic [OW-1:0] op_code;
    logic          tx_start, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_uart_bridge #(
        .DATA_BITS      (DW),
        .OP_CODE_SIZE   (OW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_dato_a     (dato_a),
        .o_dato_b     (dato_b),
        .o_op_code    (op_code),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy)
    );

    // Behavioural ALU; shifts move operand A by one place
    function automatic logic [DW-1:0] alu(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return {a[DW-1], a[DW-1:1]};
            OP_SRL:  return {1'b0, a[DW-1:1]};
            OP_NOR:  return ~(a | b);
            OP_RESET: return '0;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu(dato_a, dato_b, op_code);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: number of bytes gathered, frame in flight, cycles
    // since the opcode was accepted, idle cycles since the last byte.
    int            m_nbytes   = 0;
    bit            m_inflight = 1'b0;
    int            m_since    = 0;
    int            m_idle     = 0;
    logic [DW-1:0] m_frame [3];
    logic [DW-1:0] exp_a = '0, exp_b = '0, exp_tx = '0;
    logic [OW-1:0] exp_op = '0;
    logic          exp_start = 1'b0, exp_busy = 1'b0;
    logic [DW-1:0] exp_q [$];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_nbytes = 0; m_inflight = 1'b0; m_since = 0; m_idle = 0;
                exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
                exp_start = 1'b0;
                exp_q.delete();
            end else if (m_inflight) begin
                if (m_since >= 2 && tx_done) begin
                    m_inflight = 1'b0;
                    m_nbytes   = 0;
                end else begin
                    m_since++;
                    exp_start = (m_since == 1);
                    if (m_since == 1)
                        exp_tx = alu(m_frame[0], m_frame[1], m_frame[2][OW-1:0]);
                end
            end else if (rx_done) begin
                m_frame[m_nbytes] = rx_data;
                m_idle = 0;
                case (m_nbytes)
                    0:       exp_a  = rx_data;
                    1:       exp_b  = rx_data;
                    default: exp_op = rx_data[OW-1:0];
                endcase
                m_nbytes++;
                if (m_nbytes == 3) begin
                    m_inflight = 1'b1;
                    m_since    = 0;
                    exp_q.push_back(alu(m_frame[0], m_frame[1], m_frame[2][OW-1:0]));
                end
            end else if (m_nbytes > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_nbytes = 0;
                    m_idle   = 0;
                end
            end
            exp_busy = m_inflight || (m_nbytes > 0);
        end
    end

    // ---------------- scoreboard / compare ----------------
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            chk("dato_a",   dato_a,   exp_a);
            chk("dato_b",   dato_b,   exp_b);
            chk("op_code",  op_code,  exp_op);
            chk("tx_data",  tx_data,  exp_tx);
            chk("tx_start", tx_start, exp_start);
            chk("busy",     busy,     exp_busy);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data_sb", tx_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [DW-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Send the opcode byte, check latency/result, optionally strobe a stray
    // byte while waiting for the transmitter, then release with i_tx_done.
    task automatic finish_op(input logic [DW-1:0] op, input logic [DW-1:0] lit, input bit drop);
        int lat;
        send_byte(op);
        lat = 1;
        while (!tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("start_latency", lat, 2);
        chk("tx_data_lit", tx_data, lit);
        @(negedge clk);
        if (drop) send_byte(8'h77);
        @(negedge clk);
        pulse_tx_done();
        chk("busy_after_tx", busy, 1'b0);
    endtask

    task automatic run_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] op, input logic [DW-1:0] lit);
        send_byte(a);
        send_byte(b);
        finish_op(op, lit, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_dato_a",   dato_a,   0);
        chk("rst_dato_b",   dato_b,   0);
        chk("rst_op_code",  op_code,  0);
        chk("rst_tx_data",  tx_data,  0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy",     busy,     0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("init_busy",     busy,     0);
        chk("init_tx_start", tx_start, 0);
        chk("init_tx_data",  tx_data,  0);
        chk("init_dato_a",   dato_a,   0);
        rst = 1'b0;

        run_frame(8'h05, 8'h03, 8'h20, 8'h08);   // ADD
        run_frame(8'h03, 8'h05, 8'h22, 8'hFE);   // SUB
        run_frame(8'h80, 8'h00, 8'h03, 8'hC0);   // SRA
        run_frame(8'h05, 8'h03, 8'hE0, 8'h08);   // upper opcode bits ignored
        chk("op_mask", op_code, 6'h20);

        // Timeout after operand A: still busy one cycle before expiry
        send_byte(8'h11);
        idle(TMO - 1);
        chk("tmo_before", busy, 1);
        idle(1);
        chk("tmo_after", busy, 0);
        chk("tmo_keep_a", dato_a, 8'h11);
        run_frame(8'h01, 8'h01, 8'h20, 8'h02);

        // Operand B strobed in the expiry cycle is accepted
        send_byte(8'h21);
        idle(TMO - 1);
        send_byte(8'h34);
        chk("collide_busy", busy, 1);
        chk("collide_b", dato_b, 8'h34);
        finish_op(8'h20, 8'h55, 1'b0);

        // Stray tx_done while gathering; stray byte during WAIT_TX
        send_byte(8'h0A);
        pulse_tx_done();
        send_byte(8'h0B);
        finish_op(8'h20, 8'h15, 1'b1);
        chk("drop_keep_a", dato_a, 8'h0A);
        chk("drop_keep_b", dato_b, 8'h0B);
        run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF);   // OR

        // Reset while waiting for the opcode
        send_byte(8'h44);
        send_byte(8'h55);
        do_reset();
        run_frame(8'h06, 8'h02, 8'h22, 8'h04);

        // Reset while waiting for the transmitter
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        idle(2);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_tx", tx_data, 8'h08);
        do_reset();
        run_frame(8'h09, 8'h09, 8'h26, 8'h00);   // XOR

        idle(2);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
